// File: rtl/decodificador_sequencial_if.sv
// decodificador_sequencial_if: control/status bundle between a sequencer client and the decoder
interface decodificador_sequencial_if #(
   parameter int LARGURA = 3
);
   localparam int SAIDAS = 2 ** LARGURA;
   logic [LARGURA-1:0] entrada;
   logic [LARGURA-1:0] limite;
   logic               carrega;
   logic               avanca;
   logic               para;
   logic [SAIDAS-1:0]  saida;
   logic [LARGURA-1:0] indice;
   logic               ativo;
   logic               fim;
   modport master (
      output entrada, limite, carrega, avanca, para,
      input  saida, indice, ativo, fim
   );
   modport slave (
      input  entrada, limite, carrega, avanca, para,
      output saida, indice, ativo, fim
   );
endinterface

// File: rtl/decodificador_sequencial.sv
// decodificador_sequencial: registered N-to-2^N one-hot decoder with wrap-at-limit step sequencer
// Define DECODIFICADOR_ATIVO_BAIXO_EN for an active-low saida (idle/reset value all ones).
module decodificador_sequencial #(
   parameter int LARGURA = 3
) (
   input  logic                       clock,
   input  logic                       resetn,
   decodificador_sequencial_if.slave  bus
);
   localparam int SAIDAS = 2 ** LARGURA;
`ifdef DECODIFICADOR_ATIVO_BAIXO_EN
   localparam logic [SAIDAS-1:0] MASCARA = '1;
`else
   localparam logic [SAIDAS-1:0] MASCARA = '0;
`endif
   typedef enum logic {OCIOSO, ATIVO} estado_t;
   estado_t            estado;
   logic [LARGURA-1:0] indice;
   logic [SAIDAS-1:0]  saida;
   logic               fim;
   // polarity is folded in here so both builds share the same register stage and latency
   function automatic logic [SAIDAS-1:0] decodifica(input logic [LARGURA-1:0] i, input logic liga);
      logic [SAIDAS-1:0] v;
      v = liga ? (SAIDAS'(1) << i) : '0;
      return v ^ MASCARA;
   endfunction
   // state, index and outputs all update together; saida is decoded from the next index
   always_ff @(posedge clock) begin
      if (!resetn) begin
         estado <= OCIOSO;
         indice <= '0;
         saida  <= decodifica('0, 1'b0);
         fim    <= 1'b0;
      end else begin
         fim <= 1'b0;
         if (bus.para) begin
            estado <= OCIOSO;
            indice <= '0;
            saida  <= decodifica('0, 1'b0);
         end else if (bus.carrega) begin
            estado <= ATIVO;
            indice <= bus.entrada;
            saida  <= decodifica(bus.entrada, 1'b1);
         end else if (estado == ATIVO && bus.avanca) begin
            if (indice >= bus.limite) begin
               indice <= '0;
               saida  <= decodifica('0, 1'b1);
               fim    <= 1'b1;
            end else begin
               indice <= indice + 1'b1;
               saida  <= decodifica(indice + 1'b1, 1'b1);
            end
         end
      end
   end
   assign bus.saida  = saida;
   assign bus.indice = indice;
   assign bus.ativo  = (estado == ATIVO);
   assign bus.fim    = fim;
endmodule
